decoy: RTL and testbench
========================

DECOY -- requirements
Module: decoy

Interface
REQ-001 Parameters (name, default, meaning): SYNC_STAGES, 2, number of clk240 flip-flop stages used to synchronise pps_i and pps_trigger; legal range 2..4.
REQ-002 Ports: clk240  input  1  system clock, 240 MHz; the block has one clock and all logic SHALL run on its rising edge.
REQ-003 Ports: rst_240  input  1  reset; synchronous and active-high.
REQ-004 Ports: decoy_rst  input  1  soft reset, synchronous, active-high, from the control register path.
REQ-005 Ports: pps_i  input  1  pulse-per-second reference; asynchronous to clk240; high for about 1 us.
REQ-006 Ports: pps_trigger  input  1  arm enable; asynchronous level.
REQ-007 Ports: rng_value  input  4  random number word, valid in any cycle where rd_en_4 is high.
REQ-008 Ports: rd_en_4  input  1  RNG read strobe in the clk240 domain; typically one cycle wide, repeating every 4-6 cycles.
REQ-009 Ports: decoy_signal  output  1  decoy intensity select to the modulator driver; registered.

Function
REQ-010 The block SHALL pass pps_i through a SYNC_STAGES flip-flop synchroniser, then through one further register used for edge detection.
REQ-011 A pps rising edge SHALL be flagged for exactly one cycle when the synchronised value is 1 and the delayed value is 0.
REQ-012 The block SHALL pass pps_trigger through a separate SYNC_STAGES synchroniser; no edge detection is applied to it, it is used as a level.
REQ-013 The control FSM SHALL have three states: IDLE, ARMED and RUN.
REQ-014 FSM transition: IDLE -> ARMED when synchronised pps_trigger = 1.
REQ-015 FSM transition: ARMED -> RUN on a pps rising-edge flag.
REQ-016 FSM transition: ARMED -> IDLE when synchronised pps_trigger = 0.
REQ-017 FSM transition: RUN is left only through rst_240 or decoy_rst; later pps edges and pps_trigger going low SHALL be ignored while in RUN.
REQ-018 If a pps edge flag occurs in the same cycle that the FSM enters ARMED, it SHALL NOT cause RUN; only edges flagged while already in ARMED count.
REQ-019 In RUN, each clock edge where rd_en_4 = 1 SHALL sample rng_value.
REQ-020 Sampled decoy bit = rng_value[0].
REQ-021 On the cycle after a sample, decoy_signal SHALL be set to the sampled decoy bit.
REQ-022 decoy_signal SHALL be 0 in every cycle not immediately following a RUN-state sample with bit = 1, so each output pulse is exactly 1 cycle wide.
REQ-023 rng_value[3:1] SHALL be ignored.
REQ-024 When rd_en_4 is high on consecutive cycles, each cycle SHALL be treated as an independent sample, giving back-to-back outputs with latency 1.
REQ-025 rd_en_4 pulses while in IDLE or ARMED SHALL be discarded and SHALL produce no output.
REQ-026 A sample taken on the same edge where the FSM enters RUN SHALL be discarded.
REQ-027 Latency from the pps_i rising edge (setup met) to RUN is SYNC_STAGES+2 clk240 cycles: SYNC_STAGES to synchronise, 1 for the edge flag, 1 for the state register.

Reset
REQ-028 rst_240 and decoy_rst SHALL have identical effect; when either is high at a clock edge, the block SHALL reset.
REQ-029 Reset values: FSM = IDLE, decoy_signal = 0, all synchroniser and edge registers = 0.
REQ-030 Reset SHALL take priority over every other input in the same cycle.
REQ-031 Asserting either reset during RUN SHALL force decoy_signal to 0 on the next edge and return the FSM to IDLE.
REQ-032 After a reset, a new pps_trigger level followed by a fresh pps_i rising edge SHALL be required to re-enter RUN.
REQ-033 A pps_i that is already high when reset is released SHALL NOT produce an edge flag until it has gone low and then high again.

Verification
REQ-034 Scenario, reset: hold decoy_rst = 1 for 24 cycles with random rng_value and rd_en_4 -> decoy_signal = 0 throughout, FSM = IDLE.
REQ-035 Scenario, pre-arm: pps_trigger = 0, toggle pps_i, send rd_en_4 pulses with rng_value = 1 -> decoy_signal stays 0.
REQ-036 Scenario, arm and run: set pps_trigger = 1, then raise pps_i -> RUN after 4 cycles. Then send rd_en_4 every 6 cycles with rng_value cycling 1, 2, 3 -> decoy_signal pattern 1, 0, 1, each pulse 1 cycle wide and 1 cycle after its strobe.
REQ-037 Scenario, RUN stickiness: in RUN, drop pps_trigger and pulse pps_i again -> output continues unchanged.
REQ-038 Scenario, soft reset mid-run: assert decoy_rst for 24 cycles during RUN -> decoy_signal = 0 on the next edge. With pps_i held high at release -> no RUN until pps_i falls and rises again.
REQ-039 Scenario, back-to-back strobes: rd_en_4 high for 3 cycles with rng_value 1, 3, 0 -> decoy_signal 1, 1, 0 on the following 3 cycles.

Source files
------------

// File: rtl/decoy.sv
// Decoy intensity selector: arms on a pps_trigger level, starts on the next pps_i
// rising edge, then turns each RNG read strobe into a one-cycle decoy pulse.
module decoy #(
  parameter int unsigned SYNC_STAGES = 2  // legal range 2..4
) (
  input  logic       clk240,
  input  logic       rst_240,
  input  logic       decoy_rst,
  input  logic       pps_i,
  input  logic       pps_trigger,
  input  logic [3:0] rng_value,
  input  logic       rd_en_4,
  output logic       decoy_signal
);

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StRun
  } state_e;

  logic rst;
  assign rst = rst_240 | decoy_rst;

  logic [SYNC_STAGES-1:0] pps_sync_q;
  logic [SYNC_STAGES-1:0] trig_sync_q;
  // Marks which pps synchroniser stages hold post-reset samples rather than reset zeros.
  logic [SYNC_STAGES-1:0] sync_vld_q;
  logic                   pps_sync;
  logic                   trig_sync;
  logic                   sync_vld;
  logic                   pps_dly_q;
  logic                   pps_low_seen_q;
  logic                   pps_edge_d;
  logic                   pps_edge_q;
  state_e                 state_q;
  state_e                 state_d;
  logic                   decoy_d;
  logic                   decoy_q;

  // Upper RNG bits carry no meaning for this block.
  logic unused_rng;
  assign unused_rng = ^rng_value[3:1];

  assign pps_sync  = pps_sync_q[SYNC_STAGES-1];
  assign trig_sync = trig_sync_q[SYNC_STAGES-1];
  assign sync_vld  = sync_vld_q[SYNC_STAGES-1];

  // An edge needs a valid low sample first, so a pps_i already high at reset
  // release is not mistaken for a fresh rising edge.
  assign pps_edge_d = sync_vld & pps_sync & ~pps_dly_q & pps_low_seen_q;

  // Synchronisers, edge-detect delay and registered edge flag
  always_ff @(posedge clk240) begin
    if (rst) begin
      pps_sync_q     <= '0;
      trig_sync_q    <= '0;
      sync_vld_q     <= '0;
      pps_dly_q      <= 1'b0;
      pps_low_seen_q <= 1'b0;
      pps_edge_q     <= 1'b0;
    end else begin
      pps_sync_q     <= {pps_sync_q[SYNC_STAGES-2:0], pps_i};
      trig_sync_q    <= {trig_sync_q[SYNC_STAGES-2:0], pps_trigger};
      sync_vld_q     <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
      pps_dly_q      <= pps_sync;
      pps_low_seen_q <= pps_low_seen_q | (sync_vld & ~pps_sync);
      pps_edge_q     <= pps_edge_d;
    end
  end

  // Control FSM next state; RUN is sticky until reset
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (trig_sync) state_d = StArmed;
      end
      StArmed: begin
        if (pps_edge_q) begin
          state_d = StRun;
        end else if (!trig_sync) begin
          state_d = StIdle;
        end
      end
      StRun: begin
        state_d = StRun;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Decoy bit is taken only from strobes seen while already in RUN
  always_comb begin
    decoy_d = 1'b0;
    if (state_q == StRun) begin
      decoy_d = rd_en_4 & rng_value[0];
    end
  end

  // State and output registers
  always_ff @(posedge clk240) begin
    if (rst) begin
      state_q <= StIdle;
      decoy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      decoy_q <= decoy_d;
    end
  end

  assign decoy_signal = decoy_q;

endmodule

// File: tb/tb_decoy.sv
// Self-checking bench for decoy: sample-history model plus directed scenarios.
module tb_decoy;

  localparam int S = 2;
  localparam int MIdle  = 0;
  localparam int MArmed = 1;
  localparam int MRun   = 2;

  logic       clk240 = 1'b0;
  logic       rst_240;
  logic       decoy_rst;
  logic       pps_i;
  logic       pps_trigger;
  logic [3:0] rng_value;
  logic       rd_en_4;
  logic       decoy_signal;

  int tests  = 0;
  int fails  = 0;
  int pulses = 0;
  bit chk_en = 1'b0;

  always #5 clk240 = ~clk240;

  decoy #(
    .SYNC_STAGES(S)
  ) dut (
    .clk240      (clk240),
    .rst_240     (rst_240),
    .decoy_rst   (decoy_rst),
    .pps_i       (pps_i),
    .pps_trigger (pps_trigger),
    .rng_value   (rng_value),
    .rd_en_4     (rd_en_4),
    .decoy_signal(decoy_signal)
  );

  // Model: keeps every input sample taken since the last reset. The control
  // logic sees pps_trigger S edges late, and a 0->1 step in the sampled pps_i
  // sequence S+1 edges after its rising sample.
  int m_state = MIdle;
  int m_t     = 0;
  bit m_pps[$];
  bit m_trig[$];
  bit m_exp   = 1'b0;

  always @(posedge clk240) begin
    bit trig_v;
    bit edge_v;
    if (rst_240 || decoy_rst) begin
      m_state = MIdle;
      m_t     = 0;
      m_pps.delete();
      m_trig.delete();
      m_exp   = 1'b0;
    end else begin
      m_t++;
      m_pps.push_back(pps_i);
      m_trig.push_back(pps_trigger);
      m_exp  = (m_state == MRun) && rd_en_4 && rng_value[0];
      trig_v = (m_t > S) ? m_trig[m_t-S-1] : 1'b0;
      edge_v = (m_t > S + 2) ? (m_pps[m_t-S-2] && !m_pps[m_t-S-3]) : 1'b0;
      if (m_state == MIdle) begin
        if (trig_v) m_state = MArmed;
      end else if (m_state == MArmed) begin
        if (edge_v) m_state = MRun;
        else if (!trig_v) m_state = MIdle;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk240) begin
    if (chk_en) begin
      tests++;
      if (decoy_signal !== m_exp) begin
        fails++;
        $display("FAIL cycle_compare t=%0t decoy_signal=%b expected=%b", $time, decoy_signal,
                 m_exp);
      end
      if (decoy_signal === 1'b1) pulses++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk240);
      #1;
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int   p0;
    logic exp_seq[3];

    rst_240     = 1'b1;
    decoy_rst   = 1'b0;
    pps_i       = 1'b0;
    pps_trigger = 1'b0;
    rd_en_4     = 1'b0;
    rng_value   = 4'd0;
    step(3);
    chk_en = 1'b1;

    // Soft reset held with random traffic, including arm and pps activity
    rst_240   = 1'b0;
    decoy_rst = 1'b1;
    p0        = pulses;
    for (int i = 0; i < 24; i++) begin
      rng_value   = 4'($urandom_range(15));
      rd_en_4     = 1'($urandom_range(1));
      pps_trigger = 1'b1;
      pps_i       = i[2];
      step(1);
    end
    decoy_rst   = 1'b0;
    pps_trigger = 1'b0;
    pps_i       = 1'b0;
    rd_en_4     = 1'b0;
    step(1);
    check_int("reset_no_pulses", pulses - p0, 0);
    check_int("reset_model_idle", m_state, MIdle);

    // Pre-arm: pps toggles and strobes without trigger give nothing
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      pps_i     = 1'b1;
      rd_en_4   = 1'b1;
      rng_value = 4'd1;
      step(1);
      rd_en_4 = 1'b0;
      step(2);
      pps_i = 1'b0;
      step(3);
    end
    check_int("prearm_no_pulses", pulses - p0, 0);
    check_int("prearm_model_idle", m_state, MIdle);

    // Arm, then pps edge: RUN four edges after pps_i rises
    pps_trigger = 1'b1;
    step(6);
    check_int("armed_after_trigger", m_state, MArmed);
    pps_i = 1'b1;
    step(3);
    check_int("not_run_after_3", m_state, MArmed);
    rd_en_4   = 1'b1;
    rng_value = 4'd1;
    step(1);
    rd_en_4 = 1'b0;
    check_int("run_after_4", m_state, MRun);
    check_bit("entry_sample_dropped", decoy_signal, 1'b0);
    step(2);

    // Strobes every 6 cycles, rng 1,2,3 -> 1,0,1, one cycle wide
    exp_seq = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      rd_en_4   = 1'b1;
      rng_value = 4'(k + 1);
      step(1);
      rd_en_4 = 1'b0;
      check_bit($sformatf("run_pattern_%0d", k), decoy_signal, exp_seq[k]);
      step(1);
      check_bit($sformatf("run_width_%0d", k), decoy_signal, 1'b0);
      step(4);
    end

    // RUN stickiness: trigger dropped, new pps edge, output unaffected
    pps_trigger = 1'b0;
    pps_i       = 1'b0;
    step(4);
    pps_i = 1'b1;
    step(6);
    check_int("run_sticky", m_state, MRun);
    exp_seq = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      rd_en_4   = 1'b1;
      rng_value = (k == 0) ? 4'd1 : ((k == 1) ? 4'd5 : 4'd4);
      step(1);
      rd_en_4 = 1'b0;
      check_bit($sformatf("sticky_pattern_%0d", k), decoy_signal, exp_seq[k]);
      step(5);
    end

    // Back-to-back strobes 1,3,0 -> 1,1,0
    rd_en_4   = 1'b1;
    rng_value = 4'd1;
    step(1);
    check_bit("b2b_0", decoy_signal, 1'b1);
    rng_value = 4'd3;
    step(1);
    check_bit("b2b_1", decoy_signal, 1'b1);
    rng_value = 4'd0;
    step(1);
    check_bit("b2b_2", decoy_signal, 1'b0);
    rd_en_4 = 1'b0;
    step(1);
    check_bit("b2b_after", decoy_signal, 1'b0);
    step(3);

    // Soft reset mid-run with pps_i held high across release
    pps_i     = 1'b1;
    rd_en_4   = 1'b1;
    rng_value = 4'd1;
    step(1);
    check_bit("pre_softrst_pulse", decoy_signal, 1'b1);
    decoy_rst = 1'b1;
    step(1);
    check_bit("softrst_clears", decoy_signal, 1'b0);
    rd_en_4     = 1'b0;
    pps_trigger = 1'b1;
    for (int i = 0; i < 23; i++) begin
      rd_en_4   = 1'($urandom_range(1));
      rng_value = 4'($urandom_range(15));
      step(1);
    end
    decoy_rst = 1'b0;
    rd_en_4   = 1'b0;
    p0        = pulses;
    for (int i = 0; i < 5; i++) begin
      rd_en_4   = 1'b1;
      rng_value = 4'd1;
      step(1);
      rd_en_4 = 1'b0;
      step(3);
    end
    check_int("held_pps_no_run", pulses - p0, 0);
    check_int("held_pps_model_armed", m_state, MArmed);
    pps_i = 1'b0;
    step(4);
    pps_i = 1'b1;
    step(4);
    check_int("rerun_after_fresh_edge", m_state, MRun);
    rd_en_4   = 1'b1;
    rng_value = 4'd1;
    step(1);
    rd_en_4 = 1'b0;
    check_bit("rerun_pulse", decoy_signal, 1'b1);
    step(2);

    // Hard reset during RUN behaves like the soft reset
    rd_en_4 = 1'b1;
    rst_240 = 1'b1;
    step(1);
    check_bit("hardrst_clears", decoy_signal, 1'b0);
    check_int("hardrst_model_idle", m_state, MIdle);
    rst_240 = 1'b0;
    step(6);
    rd_en_4 = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
